// File: rtl/datapath_pkg.sv
// Shared datapath constants for the register file
// and the upstream write-register select.
package datapath_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

endpackage

// File: rtl/wdec5to32.sv
// Write-address decoder: one-hot word enables gated by we.
// Entry 0 never gets an enable, which keeps r0 at zero.
module wdec5to32
    import datapath_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    localparam int NREG = 2 ** ADDR_W
) (
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    output logic [NREG-1:0]   we_vec
);

    always_comb begin
        we_vec = '0;
        if (we && (wa != '0)) begin
            we_vec[wa] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wdec32.sv
// 32-entry register file, two operand read ports plus a debug port.
// Register 0 has no storage; optional write-through on operand ports.
module regfile_wdec32
    import datapath_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int BYPASS = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic [ADDR_W-1:0] dbg_ra,
    output logic [DATA_W-1:0] dbg_rd
);

    localparam int NREG = 2 ** ADDR_W;

    logic [NREG-1:0]   we_vec;
    logic [DATA_W-1:0] regs  [1:NREG-1];
    logic [DATA_W-1:0] rview [NREG];
    logic [DATA_W-1:0] base1;
    logic [DATA_W-1:0] base2;

    wdec5to32 #(
        .ADDR_W (ADDR_W)
    ) u_wdec (
        .we     (we),
        .wa     (wa),
        .we_vec (we_vec)
    );

    // Reset wins over a same-edge write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 1; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (we_vec[i]) begin
                    regs[i] <= wd;
                end
            end
        end
    end

    assign rview[0] = '0;

    for (genvar g = 1; g < NREG; g++) begin : g_view
        assign rview[g] = regs[g];
    end

    assign base1  = rview[ra1];
    assign base2  = rview[ra2];
    assign dbg_rd = rview[dbg_ra];

    // we_vec[ra] already excludes r0 and requires we and wa == ra.
    if (BYPASS != 0) begin : g_byp
        assign rd1 = (rst_n && we_vec[ra1]) ? wd : base1;
        assign rd2 = (rst_n && we_vec[ra2]) ? wd : base2;
    end else begin : g_nobyp
        assign rd1 = base1;
        assign rd2 = base2;
    end

endmodule

// File: tb/tb_regfile_wdec32.sv
// Self-checking bench: one instance per bypass mode, shared stimulus,
// expected values queued from a reference register model.
module tb_regfile_wdec32;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  dbg_ra;

    logic [31:0] rd1_a, rd2_a, dbg_a;
    logic [31:0] rd1_b, rd2_b, dbg_b;

    logic [31:0] mdl [32];
    logic [31:0] sb [$];

    int n_chk;
    int n_fail;

    regfile_wdec32 #(
        .DATA_W (32),
        .ADDR_W (5),
        .BYPASS (0)
    ) u_dut0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (we),
        .wa     (wa),
        .wd     (wd),
        .ra1    (ra1),
        .ra2    (ra2),
        .rd1    (rd1_a),
        .rd2    (rd2_a),
        .dbg_ra (dbg_ra),
        .dbg_rd (dbg_a)
    );

    regfile_wdec32 #(
        .DATA_W (32),
        .ADDR_W (5),
        .BYPASS (1)
    ) u_dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (we),
        .wa     (wa),
        .wd     (wd),
        .ra1    (ra1),
        .ra2    (ra2),
        .rd1    (rd1_b),
        .rd2    (rd2_b),
        .dbg_ra (dbg_ra),
        .dbg_rd (dbg_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sb_cmp(input string tag, input logic [31:0] got);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            check(tag, got, sb.pop_front());
        end
    endtask

    // Write one register on the next edge and track it in the model.
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1;
        wa = a;
        wd = d;
        @(posedge clk);
        #1;
        we = 1'b0;
        if (rst_n && a != 5'd0) mdl[a] = d;
    endtask

    // Idle read of all three ports on both instances.
    task automatic rd_all(input string tag,
                          input logic [4:0] a1,
                          input logic [4:0] a2,
                          input logic [4:0] ad);
        ra1 = a1;
        ra2 = a2;
        dbg_ra = ad;
        sb.push_back(mdl[a1]);
        sb.push_back(mdl[a2]);
        sb.push_back(mdl[ad]);
        sb.push_back(mdl[a1]);
        sb.push_back(mdl[a2]);
        sb.push_back(mdl[ad]);
        #1;
        sb_cmp({tag, "_rd1_b0"}, rd1_a);
        sb_cmp({tag, "_rd2_b0"}, rd2_a);
        sb_cmp({tag, "_dbg_b0"}, dbg_a);
        sb_cmp({tag, "_rd1_b1"}, rd1_b);
        sb_cmp({tag, "_rd2_b1"}, rd2_b);
        sb_cmp({tag, "_dbg_b1"}, dbg_b);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        rst_n = 1'b0;
        we = 1'b0;
        wa = '0;
        wd = '0;
        ra1 = '0;
        ra2 = '0;
        dbg_ra = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        rd_all("por", 5'd5, 5'd31, 5'd3);

        // Reset clears stored data and drops a same-edge write.
        wr(5'd5, 32'h1234);
        wr(5'd3, 32'h77);
        rd_all("preload", 5'd5, 5'd3, 5'd5);
        rst_n = 1'b0;
        we = 1'b1;
        wa = 5'd3;
        wd = 32'hFFFF;
        ra1 = 5'd3;
        ra2 = 5'd5;
        dbg_ra = 5'd3;
        sb.push_back(32'h77);
        sb.push_back(32'h77);
        #1;
        sb_cmp("rst_nobyp_b1", rd1_b);
        sb_cmp("rst_nobyp_b0", rd1_a);
        @(posedge clk);
        #1;
        we = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        rd_all("rst5", 5'd5, 5'd3, 5'd31);

        wr(5'd31, 32'hDEADBEEF);
        rd_all("r31", 5'd1, 5'd31, 5'd30);

        // Write to r0 is discarded, bypass included.
        we = 1'b1;
        wa = 5'd0;
        wd = 32'hFFFFFFFF;
        ra1 = 5'd0;
        sb.push_back(32'h0);
        sb.push_back(32'h0);
        #1;
        sb_cmp("zero_pre_b0", rd1_a);
        sb_cmp("zero_pre_b1", rd1_b);
        @(posedge clk);
        #1;
        we = 1'b0;
        rd_all("zero_post", 5'd0, 5'd0, 5'd0);

        // Same-cycle read of the register being written.
        wr(5'd8, 32'h11);
        we = 1'b1;
        wa = 5'd8;
        wd = 32'h22;
        ra1 = 5'd8;
        ra2 = 5'd9;
        dbg_ra = 5'd8;
        sb.push_back(32'h11);
        sb.push_back(32'h22);
        sb.push_back(32'h11);
        sb.push_back(32'h11);
        sb.push_back(32'h0);
        #1;
        sb_cmp("rw_rd1_b0", rd1_a);
        sb_cmp("rw_rd1_b1", rd1_b);
        sb_cmp("rw_dbg_b0", dbg_a);
        sb_cmp("rw_dbg_b1", dbg_b);
        sb_cmp("rw_rd2_b1", rd2_b);
        @(posedge clk);
        #1;
        we = 1'b0;
        mdl[8] = 32'h22;
        rd_all("rw_post", 5'd8, 5'd8, 5'd8);

        for (int i = 1; i < 32; i++) begin
            wr(5'(i), 32'h100 + 32'(i));
        end
        for (int i = 0; i < 32; i++) begin
            rd_all($sformatf("sweep%0d", i), 5'(i), 5'(31 - i), 5'(i));
        end

        wr(5'd17, 32'hA5A5A5A5);
        rd_all("alias", 5'd17, 5'd17, 5'd17);

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got stuck expected finish");
        $fatal(1, "timeout");
    end

endmodule
